// File: rtl/tx_ethernet.sv
// GMII transmit framer: preamble, header, payload, pad, FCS, IFG.
`timescale 1ns/1ps
module tx_ethernet #(
  parameter int              OCT         = 8,
  parameter logic [OCT-1:0]  PRE         = 8'b10101010,
  parameter logic [OCT-1:0]  SFD         = 8'b10101011,
  parameter int              PRE_LEN     = 7,
  parameter int              MIN_PAYLOAD = 46,
  parameter int              IFG_LEN     = 12
) (
  input  logic             TX_CLK,
  input  logic             rst,
  input  logic [OCT*6-1:0] mac_addr,
  input  logic             tx_start,
  input  logic [OCT*6-1:0] tx_mac_dst,
  input  logic [OCT*2-1:0] tx_len_type,
  input  logic [OCT-1:0]   tx_payload,
  input  logic             tx_payload_valid,
  input  logic             tx_payload_last,
  output logic             tx_payload_ready,
  output logic             tx_busy,
  output logic             tx_done,
  output logic             TX_EN,
  output logic [OCT-1:0]   TXD,
  output logic             TX_ER
);

  localparam logic [31:0] POLY     = 32'hEDB88320;
  localparam logic [3:0]  PRE_LAST = 4'(PRE_LEN - 1);
  localparam logic [3:0]  IFG_LAST = 4'(IFG_LEN - 1);
  localparam logic [10:0] MIN_P    = 11'(MIN_PAYLOAD);

  typedef enum logic [3:0] {
    S_IDLE, S_PRE, S_SFD, S_DST, S_SRC,
    S_LT, S_DATA, S_PAD, S_FCS, S_IFG
  } state_t;

  state_t             state;
  logic [3:0]         cnt;
  logic [10:0]        pcnt;
  logic [10:0]        pcnt_inc;
  logic [OCT*6-1:0]   dst_q;
  logic [OCT*6-1:0]   src_q;
  logic [OCT*2-1:0]   lt_q;
  logic [31:0]        crc;

  function automatic logic [31:0] crc_next(
    input logic [31:0]  c,
    input logic [OCT-1:0] d
  );
    logic [31:0] r;
    r = c ^ {{(32-OCT){1'b0}}, d};
    for (int i = 0; i < OCT; i++)
      r = r[0] ? ((r >> 1) ^ POLY) : (r >> 1);
    return r;
  endfunction

  // payload+pad octet count saturates rather than wrapping
  always_comb begin
    pcnt_inc = pcnt;
    if (pcnt != 11'h7FF)
      pcnt_inc = pcnt + 11'd1;
  end

  assign tx_payload_ready = (state == S_DATA);

  always_ff @(posedge TX_CLK) begin
    if (rst) begin
      state   <= S_IDLE;
      cnt     <= '0;
      pcnt    <= '0;
      dst_q   <= '0;
      src_q   <= '0;
      lt_q    <= '0;
      crc     <= 32'hFFFFFFFF;
      tx_busy <= 1'b0;
      tx_done <= 1'b0;
      TX_EN   <= 1'b0;
      TX_ER   <= 1'b0;
      TXD     <= '0;
    end else begin
      tx_done <= 1'b0;
      TX_EN   <= 1'b0;
      TX_ER   <= 1'b0;
      TXD     <= '0;
      unique case (state)
        S_IDLE: begin
          crc  <= 32'hFFFFFFFF;
          cnt  <= '0;
          pcnt <= '0;
          if (tx_start) begin
            dst_q   <= tx_mac_dst;
            src_q   <= mac_addr;
            lt_q    <= tx_len_type;
            tx_busy <= 1'b1;
            state   <= S_PRE;
          end
        end
        S_PRE: begin
          TX_EN <= 1'b1;
          TXD   <= PRE;
          if (cnt == PRE_LAST) begin
            cnt   <= '0;
            state <= S_SFD;
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        S_SFD: begin
          TX_EN <= 1'b1;
          TXD   <= SFD;
          crc   <= 32'hFFFFFFFF;
          cnt   <= '0;
          state <= S_DST;
        end
        S_DST: begin
          TX_EN <= 1'b1;
          TXD   <= dst_q[OCT*6-1 -: OCT];
          crc   <= crc_next(crc, dst_q[OCT*6-1 -: OCT]);
          dst_q <= dst_q << OCT;
          if (cnt == 4'd5) begin
            cnt   <= '0;
            state <= S_SRC;
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        S_SRC: begin
          TX_EN <= 1'b1;
          TXD   <= src_q[OCT*6-1 -: OCT];
          crc   <= crc_next(crc, src_q[OCT*6-1 -: OCT]);
          src_q <= src_q << OCT;
          if (cnt == 4'd5) begin
            cnt   <= '0;
            state <= S_LT;
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        S_LT: begin
          TX_EN <= 1'b1;
          TXD   <= lt_q[OCT*2-1 -: OCT];
          crc   <= crc_next(crc, lt_q[OCT*2-1 -: OCT]);
          lt_q  <= lt_q << OCT;
          if (cnt == 4'd1) begin
            cnt   <= '0;
            state <= S_DATA;
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        S_DATA: begin
          TX_EN <= 1'b1;
          cnt   <= '0;
          if (tx_payload_valid) begin
            TXD  <= tx_payload;
            crc  <= crc_next(crc, tx_payload);
            pcnt <= pcnt_inc;
            if (tx_payload_last)
              state <= (pcnt_inc < MIN_P) ? S_PAD : S_FCS;
          end else begin
            // underrun: poison the frame and skip the FCS
            TX_ER <= 1'b1;
            state <= S_IFG;
          end
        end
        S_PAD: begin
          TX_EN <= 1'b1;
          crc   <= crc_next(crc, '0);
          pcnt  <= pcnt_inc;
          if (pcnt_inc >= MIN_P)
            state <= S_FCS;
        end
        S_FCS: begin
          TX_EN <= 1'b1;
          TXD   <= ~crc[OCT-1:0];
          crc   <= crc >> OCT;
          if (cnt == 4'd3) begin
            cnt   <= '0;
            state <= S_IFG;
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        S_IFG: begin
          if (cnt == IFG_LAST) begin
            cnt     <= '0;
            tx_done <= 1'b1;
            tx_busy <= 1'b0;
            state   <= S_IDLE;
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tx_ethernet.sv
// Directed bench for tx_ethernet: vector table of frames plus
// reset-mid-frame and busy-rejection sequences.
`timescale 1ns/1ps
module tb_tx_ethernet;

  localparam logic [31:0] RESIDUE = 32'hDEBB20E3;

  logic        TX_CLK = 1'b0;
  logic        rst;
  logic [47:0] mac_addr;
  logic        tx_start;
  logic [47:0] tx_mac_dst;
  logic [15:0] tx_len_type;
  logic [7:0]  tx_payload;
  logic        tx_payload_valid;
  logic        tx_payload_last;
  logic        tx_payload_ready;
  logic        tx_busy;
  logic        tx_done;
  logic        TX_EN;
  logic [7:0]  TXD;
  logic        TX_ER;

  int checks = 0;
  int errors = 0;

  always #5 TX_CLK = ~TX_CLK;

  tx_ethernet dut (
    .TX_CLK           (TX_CLK),
    .rst              (rst),
    .mac_addr         (mac_addr),
    .tx_start         (tx_start),
    .tx_mac_dst       (tx_mac_dst),
    .tx_len_type      (tx_len_type),
    .tx_payload       (tx_payload),
    .tx_payload_valid (tx_payload_valid),
    .tx_payload_last  (tx_payload_last),
    .tx_payload_ready (tx_payload_ready),
    .tx_busy          (tx_busy),
    .tx_done          (tx_done),
    .TX_EN            (TX_EN),
    .TXD              (TXD),
    .TX_ER            (TX_ER)
  );

  typedef struct {
    logic [47:0] dst;
    logic [47:0] src;
    logic [15:0] lt;
    int          len;
    int          under;
    int          exp_en;
    int          exp_pad;
    int          exp_rdy;
    int          exp_er;
  } vec_t;

  vec_t vt[4];

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // serial LFSR form of the reflected CRC-32
  function automatic logic [31:0] crc_ser(input logic [31:0] c,
                                          input logic [7:0] d);
    logic [31:0] r;
    logic        fb;
    r = c;
    for (int b = 0; b < 8; b++) begin
      fb = r[0] ^ d[b];
      r  = r >> 1;
      if (fb) r = r ^ 32'hEDB88320;
    end
    return r;
  endfunction

  task automatic run_frame(input vec_t v, input bit poke, input string tag);
    logic [7:0] cap[0:255];
    logic       cer[0:255];
    logic [7:0] hdr[0:21];
    logic [7:0] d2[0:13];
    logic [31:0] c;
    int en, er, rdy, idx, s, first_en, idle, idle_done, off_bad, bad;
    int npay, lastb, g, n2;
    bit busy0, done, poked, seen;
    en = 0; er = 0; rdy = 0; idx = 0; s = 0; first_en = -1;
    idle = 0; idle_done = -1; off_bad = 0;
    busy0 = 0; done = 0; poked = 0;
    for (int i = 0; i < 7; i++) hdr[i] = 8'hAA;
    hdr[7] = 8'hAB;
    for (int i = 0; i < 6; i++) begin
      hdr[8+i]  = v.dst[47-8*i -: 8];
      hdr[14+i] = v.src[47-8*i -: 8];
    end
    hdr[20] = v.lt[15:8];
    hdr[21] = v.lt[7:0];

    @(negedge TX_CLK);
    tx_mac_dst  = v.dst;
    mac_addr    = v.src;
    tx_len_type = v.lt;
    tx_start    = 1'b1;
    while (!done && s < 400) begin
      @(negedge TX_CLK);
      if (s == 0) begin
        busy0    = tx_busy;
        tx_start = 1'b0;
      end
      if (TX_EN) begin
        if (first_en < 0) first_en = s;
        if (en < 256) begin
          cap[en] = TXD;
          cer[en] = TX_ER;
        end
        en++;
        idle = 0;
      end else begin
        if (TXD != 8'h00) off_bad++;
        if (first_en >= 0) idle++;
      end
      if (TX_ER) er++;
      if (tx_payload_ready) rdy++;
      if (tx_done) begin
        done      = 1;
        idle_done = idle;
      end
      if (tx_payload_ready && idx < v.len && idx != v.under) begin
        tx_payload_valid = 1'b1;
        tx_payload       = 8'(idx);
        tx_payload_last  = (idx == v.len - 1);
        idx++;
      end else begin
        tx_payload_valid = 1'b0;
        tx_payload_last  = 1'b0;
      end
      if (poke && !poked && idx == 5) begin
        tx_mac_dst = 48'hDEADBEEF0000;
        tx_start   = 1'b1;
        poked      = 1;
      end
      s++;
    end
    tx_payload_valid = 1'b0;
    tx_payload_last  = 1'b0;

    chk({tag, "_done_seen"}, 64'(done), 64'd1);
    chk({tag, "_busy_at_start"}, 64'(busy0), 64'd1);
    chk({tag, "_latency"}, 64'(first_en), 64'd1);
    chk({tag, "_en_cycles"}, 64'(en), 64'(v.exp_en));
    chk({tag, "_er_cycles"}, 64'(er), 64'(v.exp_er));
    chk({tag, "_ready_cycles"}, 64'(rdy), 64'(v.exp_rdy));
    bad = 0;
    for (int i = 0; i < 22; i++)
      if (cap[i] !== hdr[i]) bad++;
    chk({tag, "_header_bad"}, 64'(bad), 64'd0);
    npay = (v.under >= 0) ? v.under : v.len;
    bad = 0;
    for (int i = 0; i < npay; i++)
      if (cap[22+i] !== 8'(i)) bad++;
    chk({tag, "_payload_bad"}, 64'(bad), 64'd0);
    bad = 0;
    for (int i = 0; i < v.exp_pad; i++)
      if (cap[22+v.len+i] !== 8'h00) bad++;
    chk({tag, "_pad_bad"}, 64'(bad), 64'd0);
    if (v.under < 0) begin
      c = 32'hFFFFFFFF;
      for (int i = 8; i < en && i < 256; i++) c = crc_ser(c, cap[i]);
      chk({tag, "_crc_residue"}, 64'(c), 64'(RESIDUE));
    end else begin
      lastb = (en > 0) ? en - 1 : 0;
      chk({tag, "_er_octet"}, 64'({cer[lastb], cap[lastb]}), 64'h100);
    end
    chk({tag, "_ifg_cycles"}, 64'(idle_done), 64'd12);
    chk({tag, "_txd_while_off"}, 64'(off_bad), 64'd0);

    if (!poke) begin
      @(negedge TX_CLK);
      chk({tag, "_post_done"}, 64'({tx_done, tx_busy}), 64'd0);
    end else begin
      g = 0;
      seen = 0;
      while (!seen && g < 10) begin
        @(negedge TX_CLK);
        g++;
        if (TX_EN) seen = 1;
      end
      chk({tag, "_restart_gap"}, 64'(g), 64'd2);
      d2[0] = TXD;
      n2 = 1;
      while (n2 < 14) begin
        @(negedge TX_CLK);
        d2[n2] = TXD;
        n2++;
      end
      chk({tag, "_new_dst"},
          64'({d2[8], d2[9], d2[10], d2[11], d2[12], d2[13]}),
          64'h0000DEADBEEF0000);
      tx_start = 1'b0;
      rst = 1'b1;
      repeat (2) @(negedge TX_CLK);
      rst = 1'b0;
    end
  endtask

  initial begin
    vt[0] = '{48'h001122334455, 48'h0A0B0C0D0E0F, 16'h0800,
              46, -1, 72, 0, 46, 0};
    vt[1] = '{48'h665544332211, 48'h0A0B0C0D0E0F, 16'h000A,
              10, -1, 72, 36, 10, 0};
    vt[2] = '{48'hFFFFFFFFFFFF, 48'h020000000001, 16'h0064,
              100, -1, 126, 0, 100, 0};
    vt[3] = '{48'h001122334455, 48'h0A0B0C0D0E0F, 16'h0800,
              30, 19, 42, 0, 20, 1};

    rst              = 1'b1;
    tx_start         = 1'b0;
    mac_addr         = '0;
    tx_mac_dst       = '0;
    tx_len_type      = '0;
    tx_payload       = '0;
    tx_payload_valid = 1'b0;
    tx_payload_last  = 1'b0;
    repeat (3) @(negedge TX_CLK);
    chk("reset_ctrl",
        64'({TX_EN, TX_ER, tx_busy, tx_done, tx_payload_ready}), 64'd0);
    chk("reset_txd", 64'(TXD), 64'd0);
    rst = 1'b0;
    repeat (2) @(negedge TX_CLK);
    chk("idle_after_reset", 64'({TX_EN, tx_busy}), 64'd0);

    for (int k = 0; k < 4; k++)
      run_frame(vt[k], 1'b0, $sformatf("v%0d", k));

    // reset while the source MAC is on the wire
    @(negedge TX_CLK);
    tx_mac_dst  = 48'h001122334455;
    mac_addr    = 48'h0A0B0C0D0E0F;
    tx_len_type = 16'h0800;
    tx_start    = 1'b1;
    @(negedge TX_CLK);
    tx_start = 1'b0;
    repeat (17) @(negedge TX_CLK);
    chk("mid_src_byte", 64'({TX_EN, TXD}), 64'h10C);
    rst = 1'b1;
    @(negedge TX_CLK);
    chk("mid_rst_ctrl",
        64'({TX_EN, TX_ER, tx_busy, tx_done, tx_payload_ready}), 64'd0);
    chk("mid_rst_txd", 64'(TXD), 64'd0);
    rst = 1'b0;
    run_frame(vt[0], 1'b0, "after_rst");

    run_frame(vt[0], 1'b1, "busy");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
